// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer.
// Moore FSM for main/side lamps and the pedestrian walk lamp. A tick-enabled
// interval counter is reloaded on every state change; a state is left only
// when its interval completes (done = tick && q == dur-1).
// Outputs are registered from the next-state values, so they carry exactly the
// timing of a decode of the state register while staying glitch-free.
module traffic_light_ctrl #(
   parameter int unsigned COUNTER_BITS = 6,
   parameter int unsigned T_GREEN      = 30,
   parameter int unsigned T_SIDE       = 15,
   parameter int unsigned T_YELLOW     = 3,
   parameter int unsigned T_ALLRED     = 2,
   parameter int unsigned T_FLASH      = 1
) (
   input  logic                    clk,
   input  logic                    r_n,
   input  logic                    tick,
   input  logic                    side_car,
   input  logic                    ped_req,
   input  logic                    night,
   output logic [2:0]              main_lamp,
   output logic [2:0]              side_lamp,
   output logic                    ped_walk,
   output logic [COUNTER_BITS-1:0] remain
);

   localparam int unsigned CB = COUNTER_BITS;

   localparam logic [2:0] ST_MG  = 3'd0;
   localparam logic [2:0] ST_MY  = 3'd1;
   localparam logic [2:0] ST_AR1 = 3'd2;
   localparam logic [2:0] ST_SG  = 3'd3;
   localparam logic [2:0] ST_SY  = 3'd4;
   localparam logic [2:0] ST_AR2 = 3'd5;
   localparam logic [2:0] ST_FL  = 3'd6;

   localparam logic [CB-1:0] DUR_GREEN  = CB'(T_GREEN);
   localparam logic [CB-1:0] DUR_SIDE   = CB'(T_SIDE);
   localparam logic [CB-1:0] DUR_YELLOW = CB'(T_YELLOW);
   localparam logic [CB-1:0] DUR_ALLRED = CB'(T_ALLRED);
   localparam logic [CB-1:0] DUR_FLASH  = CB'(T_FLASH);
   localparam logic [CB-1:0] ONE        = CB'(1);

   // Interval length of each state, in ticks.
   function automatic logic [CB-1:0] dur_of(input logic [2:0] st);
      case (st)
         ST_MG:         dur_of = DUR_GREEN;
         ST_SG:         dur_of = DUR_SIDE;
         ST_MY, ST_SY:  dur_of = DUR_YELLOW;
         ST_AR1:        dur_of = DUR_ALLRED;
         ST_AR2:        dur_of = DUR_ALLRED;
         ST_FL:         dur_of = DUR_FLASH;
         default:       dur_of = DUR_ALLRED;
      endcase
   endfunction

   // Lamp decode: {main RYG, side RYG, walk}. Unknown codes show all-red.
   function automatic logic [6:0] lamps_of(input logic [2:0] st, input logic fl);
      case (st)
         ST_MG:          lamps_of = {3'b001, 3'b100, 1'b0};
         ST_MY:          lamps_of = {3'b010, 3'b100, 1'b0};
         ST_AR1, ST_AR2: lamps_of = {3'b100, 3'b100, 1'b0};
         ST_SG:          lamps_of = {3'b100, 3'b001, 1'b1};
         ST_SY:          lamps_of = {3'b100, 3'b010, 1'b0};
         ST_FL:          lamps_of = {1'b0, fl, 1'b0, 1'b0, fl, 1'b0, 1'b0};
         default:        lamps_of = {3'b100, 3'b100, 1'b0};
      endcase
   endfunction

   logic [2:0]    state_q, state_d;
   logic [CB-1:0] cnt_q, cnt_d;
   logic          req_q, req_d;
   logic          flash_q, flash_d;
   logic [6:0]    lamps_q;
   logic [CB-1:0] remain_q;
   logic          done_s;

   // Next state, interval counter, flash phase and pending-request logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flash_d = flash_q;
      done_s  = tick && (cnt_q == (dur_of(state_q) - ONE));
      if (done_s) begin
         cnt_d = '0;
         case (state_q)
            ST_MG: begin
               if (night) begin
                  state_d = ST_FL;
                  flash_d = 1'b1;   // flash starts with the yellows lit
               end else if (req_q) begin
                  state_d = ST_MY;
               end else begin
                  state_d = ST_MG;  // stay; interval restarts
               end
            end
            ST_MY:  state_d = ST_AR1;
            ST_AR1: state_d = ST_SG;
            ST_SG:  state_d = ST_SY;
            ST_SY:  state_d = ST_AR2;
            ST_AR2: begin
               if (night) begin
                  state_d = ST_FL;
                  flash_d = 1'b1;
               end else begin
                  state_d = ST_MG;
               end
            end
            ST_FL: begin
               if (night) begin
                  flash_d = ~flash_q;
               end else begin
                  state_d = ST_AR2;
                  flash_d = 1'b0;
               end
            end
            default: begin
               state_d = ST_AR2;
               flash_d = 1'b0;
            end
         endcase
      end else if (tick) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
      // Entering side green serves the request; that wins over a new one.
      if (done_s && (state_q == ST_AR1)) begin
         req_d = 1'b0;
      end else begin
         req_d = req_q | side_car | ped_req;
      end
   end

   // State, counter, request and registered outputs; reset lands in AR2.
   always_ff @(posedge clk or negedge r_n) begin
      if (!r_n) begin
         state_q  <= ST_AR2;
         cnt_q    <= '0;
         req_q    <= 1'b0;
         flash_q  <= 1'b0;
         lamps_q  <= {3'b100, 3'b100, 1'b0};
         remain_q <= CB'(T_ALLRED - 1);
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         req_q    <= req_d;
         flash_q  <= flash_d;
         lamps_q  <= lamps_of(state_d, flash_d);
         remain_q <= dur_of(state_d) - ONE - cnt_d;
      end
   end

   assign main_lamp = lamps_q[6:4];
   assign side_lamp = lamps_q[3:1];
   assign ped_walk  = lamps_q[0];
   assign remain    = remain_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus random
// traffic, all compared against a phase-table reference model.
module tb_traffic_light_ctrl;

   logic       clk = 1'b0;
   logic       r_n = 1'b0;
   logic       tick = 1'b0;
   logic       side_car = 1'b0;
   logic       ped_req = 1'b0;
   logic       night = 1'b0;
   logic [2:0] main_lamp;
   logic [2:0] side_lamp;
   logic       ped_walk;
   logic [5:0] remain;

   int vectors = 0;
   int miscompares = 0;

   traffic_light_ctrl dut (
      .clk(clk), .r_n(r_n), .tick(tick), .side_car(side_car),
      .ped_req(ped_req), .night(night), .main_lamp(main_lamp),
      .side_lamp(side_lamp), .ped_walk(ped_walk), .remain(remain)
   );

   always #5 clk = ~clk;

   // Reference model: phases 0..6 = main green, main yellow, all-red to side,
   // side green, side yellow, all-red to main, night flash.
   int         dur_t [7] = '{30, 3, 2, 15, 3, 2, 1};
   logic [2:0] main_t[7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
   logic [2:0] side_t[7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
   int m_ph, m_el;
   bit m_req, m_flash;

   wire [12:0] act = {main_lamp, side_lamp, ped_walk, remain};

   function automatic logic [12:0] exp_vec();
      logic [2:0] mn, sd;
      logic [5:0] rem;
      mn  = (m_ph == 6) ? {1'b0, m_flash, 1'b0} : main_t[m_ph];
      sd  = (m_ph == 6) ? {1'b0, m_flash, 1'b0} : side_t[m_ph];
      rem = 6'(dur_t[m_ph] - 1 - m_el);
      return {mn, sd, (m_ph == 3), rem};
   endfunction

   task automatic model_reset();
      m_ph = 5; m_el = 0; m_req = 0; m_flash = 0;
   endtask

   task automatic model_step(input bit t, input bit sc, input bit pr, input bit nt);
      bit fin, served;
      fin    = t && (m_el == dur_t[m_ph] - 1);
      served = fin && (m_ph == 2);
      if (fin) begin
         m_el = 0;
         case (m_ph)
            0: if (nt) begin m_ph = 6; m_flash = 1; end else if (m_req) m_ph = 1;
            1, 2, 3, 4: m_ph = m_ph + 1;
            5: if (nt) begin m_ph = 6; m_flash = 1; end else m_ph = 0;
            6: if (nt) m_flash = ~m_flash; else begin m_ph = 5; m_flash = 0; end
            default: ;
         endcase
      end else if (t) begin
         m_el = m_el + 1;
      end
      m_req = served ? 1'b0 : (m_req | sc | pr);
   endtask

   // One clock: drive inputs at the falling edge, step model at the rising edge.
   task automatic advance(input bit t, input bit sc, input bit pr, input bit nt);
      tick = t; side_car = sc; ped_req = pr; night = nt;
      @(posedge clk);
      if (r_n) model_step(t, sc, pr, nt); else model_reset();
      @(negedge clk);
   endtask

   // Tick every clock until the model reaches (phase, elapsed), bounded.
   task automatic run_until(input int ph, input int el, input bit nt);
      int n;
      n = 0;
      while (!(m_ph == ph && m_el == el) && n < 300) begin
         advance(1, 0, 0, nt);
         n++;
      end
      vectors++;
      if (!(m_ph == ph && m_el == el)) begin
         miscompares++;
         $display("FAIL run_until: phase %0d el %0d not reached, got phase %0d el %0d", ph, el, m_ph, m_el);
      end
   endtask

   task automatic test_reset();
      r_n = 1'b0;
      model_reset();
      #12;
      vectors++;
      if (act !== {3'b100, 3'b100, 1'b0, 6'd1}) begin
         miscompares++;
         $display("FAIL reset_state: got %b want %b", act, {3'b100, 3'b100, 1'b0, 6'd1});
      end
      @(negedge clk);
      r_n = 1'b1;
   endtask

   task automatic test_idle_cycle();
      for (int i = 0; i < 70; i++) begin
         advance(1, 0, 0, 0);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL idle: cyc %0d got %b want %b", i, act, exp_vec());
         end
         if (i >= 2) begin
            vectors++;
            if (main_lamp !== 3'b001) begin
               miscompares++;
               $display("FAIL idle_main_green: cyc %0d got %b want 001", i, main_lamp);
            end
         end
      end
   endtask

   task automatic test_side_request();
      run_until(0, 5, 0);
      advance(1, 1, 0, 0);
      for (int i = 0; i < 90; i++) begin
         advance(1, 0, 0, 0);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL side_request: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
   endtask

   task automatic test_ped_at_sg_entry();
      run_until(0, 3, 0);
      advance(1, 1, 0, 0);
      run_until(2, 1, 0);
      advance(1, 0, 1, 0);          // ped press on the edge entering side green
      run_until(0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         advance(1, 0, 0, 0);
         vectors++;
         if (act !== exp_vec() || main_lamp !== 3'b001) begin
            miscompares++;
            $display("FAIL ped_at_sg_entry: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
   endtask

   task automatic test_night();
      run_until(0, 2, 0);
      advance(1, 1, 0, 0);
      run_until(3, 4, 0);
      for (int i = 0; i < 30; i++) begin
         advance(1, 0, 0, 1);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL night_enter: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
      for (int i = 0; i < 10; i++) begin
         advance(1, 0, 0, 0);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL night_exit: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
   endtask

   task automatic test_tick_gate();
      run_until(0, 10, 0);
      for (int i = 0; i < 100; i++) begin
         advance(0, 0, 0, 0);
         vectors++;
         if (act !== exp_vec() || remain !== 6'd19 || main_lamp !== 3'b001) begin
            miscompares++;
            $display("FAIL tick_gate: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
      for (int i = 0; i < 25; i++) begin
         advance(1, 0, 0, 0);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL tick_resume: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
   endtask

   task automatic test_async_reset();
      run_until(0, 1, 0);
      advance(1, 1, 0, 0);
      run_until(4, 1, 0);
      #2 r_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (act !== {3'b100, 3'b100, 1'b0, 6'd1}) begin
         miscompares++;
         $display("FAIL async_reset: got %b want %b", act, {3'b100, 3'b100, 1'b0, 6'd1});
      end
      @(negedge clk);
      r_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         advance(1, 0, 0, 0);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL after_reset: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
   endtask

   task automatic test_random();
      bit nt;
      nt = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 250) == 0) nt = ~nt;
         advance($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
                 $urandom_range(0, 80) == 0, nt);
         vectors++;
         if (act !== exp_vec()) begin
            miscompares++;
            $display("FAIL random: cyc %0d got %b want %b", i, act, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle_cycle();
      test_side_request();
      test_ped_at_sg_entry();
      test_night();
      test_tick_gate();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
